// File: rtl/fifo_deq_stage.sv
// ---------------------------------------------------------------------------
// fifo_deq_stage
//
// Pop-side consumer for the team FIFO. Drains the FIFO's combinational head
// (fifo_rdata / fifo_empty) into a 2-entry skid buffer and presents it
// downstream as a registered valid/ready stream. fifo_ren depends only on
// registered state and the FIFO flags, so no combinational path runs from
// out_ready back to the FIFO.
//
// Optional feature macro: FIFO_DEQ_FLUSH_EN
//   defined   -> flush clears the buffer in one cycle and suppresses fifo_ren
//   undefined -> flush is ignored (port kept; tie it to 0)
//
// Parameters:
//   WIDTH       payload width used by the default DTYPE
//   DTYPE       payload type, must match the FIFO's DTYPE
//
// Ports:
//   clk         clock, all state updates on posedge
//   rst         synchronous active-high reset
//   fifo_empty  FIFO empty flag
//   fifo_rdata  FIFO head data, valid while fifo_empty = 0
//   fifo_ren    pop strobe to the FIFO
//   out_valid   downstream data valid (buffer non-empty)
//   out_data    downstream payload (buffer head)
//   out_ready   downstream accept
//   flush       discard buffered entries (only with FIFO_DEQ_FLUSH_EN)
//   count       buffer occupancy, 0..2
// ---------------------------------------------------------------------------
module fifo_deq_stage #(
    parameter int  WIDTH = 32,
    parameter type DTYPE = logic [WIDTH-1:0]
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fifo_empty,
    input  DTYPE       fifo_rdata,
    output logic       fifo_ren,
    output logic       out_valid,
    output DTYPE       out_data,
    input  logic       out_ready,
    input  logic       flush,
    output logic [1:0] count
);

    // State encoding equals the occupancy, so count is the state register.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;
    DTYPE   buf0;
    DTYPE   buf1;
    DTYPE   buf0_next;
    DTYPE   buf1_next;
    logic   flush_eff;
    logic   push;
    logic   pop;

`ifdef FIFO_DEQ_FLUSH_EN
    assign flush_eff = flush;
`else
    // Port kept for a uniform interface; its value is deliberately unused.
    logic flush_unused;
    assign flush_unused = flush;
    assign flush_eff    = 1'b0;
`endif

    // Pop only when there is room; never looks at out_ready.
    assign fifo_ren  = ~rst & ~fifo_empty & (state != FULL) & ~flush_eff;
    assign push      = fifo_ren;
    assign out_valid = (state != EMPTY);
    assign pop       = out_valid & out_ready;
    assign out_data  = buf0;
    assign count     = state;

    // State and buffer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
            buf0  <= '0;
            buf1  <= '0;
        end else begin
            state <= state_next;
            buf0  <= buf0_next;
            buf1  <= buf1_next;
        end
    end

    // Next-state and buffer-update logic. buf0 is always the oldest entry;
    // buf1 only fills when the head is stalled, and drains into buf0 on pop.
    always_comb begin
        state_next = state;
        buf0_next  = buf0;
        buf1_next  = buf1;
        if (flush_eff) begin
            // Buffer contents are left as-is; only occupancy is cleared.
            state_next = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        buf0_next  = fifo_rdata;
                        state_next = ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        buf0_next = fifo_rdata;
                    end else if (push) begin
                        buf1_next  = fifo_rdata;
                        state_next = FULL;
                    end else if (pop) begin
                        state_next = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        buf0_next  = buf1;
                        state_next = ONE;
                    end
                end
                default: begin
                    state_next = EMPTY;
                end
            endcase
        end
    end

endmodule

// File: doc/fifo_deq_stage.md
# fifo_deq_stage

Pop-side consumer for the team's `fifo` block: drains the FIFO's combinational `rdata`/`empty` head and presents it downstream as a registered valid/ready stream. A 2-entry skid buffer keeps full throughput while cutting every combinational path from downstream `out_ready` back to the FIFO's `ren`. It sits between any instruction/response queue and the pipeline stage that consumes it, and supports a flush on mispredict.

## Interface
- `WIDTH`, default 32: payload width when `DTYPE` is not overridden.
- `DTYPE`, default `logic[WIDTH-1:0]`: payload type; must match the FIFO's `DTYPE`.
- `clk`  in  1  clock; all state updates on the posedge.
- `rst`  in  1  reset; synchronous, active-high.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_rdata`  in  DTYPE  FIFO head data; valid whenever `fifo_empty`=0.
- `fifo_ren`  out  1  pop strobe to the FIFO's `ren`.
- `out_valid`  out  1  downstream data valid.
- `out_data`  out  DTYPE  downstream payload (the buffer head).
- `out_ready`  in  1  downstream accept.
- `flush`  in  1  discard buffered entries; honoured only with `FIFO_DEQ_FLUSH_EN`.
- `count`  out  2  buffer occupancy, 0..2.

## Operation
- Storage: `buf0` (head) and `buf1` (skid), plus a 2-bit `count`. States are EMPTY (count=0), ONE (count=1) and FULL (count=2).
- `fifo_ren = ~rst & ~fifo_empty & (count != 2) & ~flush_eff`. It is a function of registered state and FIFO flags only, never of `out_ready`.
- `out_valid = (count != 0)` and `out_data = buf0`. Both are registered.
- Define `push = fifo_ren` and `pop = out_valid & out_ready`.
- EMPTY: on push, `buf0` takes `fifo_rdata` and the state goes to ONE.
- ONE, push only: `buf1` takes `fifo_rdata` and the state goes to FULL.
- ONE, pop only: the state goes to EMPTY.
- ONE, push and pop: `buf0` takes `fifo_rdata` and the state stays ONE.
- FULL, pop: `buf0` takes `buf1` and the state goes to ONE. No push is possible in FULL.
- FULL, no pop: hold.
- Ordering is strict FIFO; no entry is duplicated or dropped except by flush.
- `flush_eff` is `flush` when `FIFO_DEQ_FLUSH_EN` is defined, otherwise 0. When `flush_eff`=1:
  - `count` goes to 0.
  - `fifo_ren` is held at 0 in that cycle.
  - Any `pop` in that cycle is also discarded.
  - The FIFO contents are not touched; the parent resets the FIFO if it needs it emptied.
- `out_valid` must not drop while `out_ready`=0, except through reset or flush.
- `out_data` must stay stable while `out_valid`=1 and `out_ready`=0.

## Timing
- Reset: `count`=0, `out_valid`=0, `out_data`='0, `fifo_ren`=0 during the reset cycle. `buf1` resets to '0.
- Latency: a FIFO head popped in cycle N appears on `out_data` with `out_valid`=1 in cycle N+1.
- Throughput: one item per cycle in steady state with `out_ready`=1 (the ONE state with push and pop together).
- Backpressure: with `out_ready`=0, at most 2 further items are popped from the FIFO, after which `fifo_ren`=0.
- Recovery: after FULL, `out_ready`=1 gives one transfer per cycle with no bubble.
- The FIFO going empty mid-stream only inserts bubbles; those bubbles are visible as `out_valid`=0.
- `rst` mid-operation drops both buffered entries on the next edge. Entries already popped from the FIFO are lost; this is intended.

## Configuration
- `FIFO_DEQ_FLUSH_EN` defined: `flush` behaves as described above, with one-cycle clear and `fifo_ren` suppressed in the flush cycle.
- `FIFO_DEQ_FLUSH_EN` undefined: the `flush` port still exists but is ignored (`flush_eff`=0). Integrators tie it to 0.

## Test plan
- Reset with a non-empty FIFO: during the `rst` cycle, `fifo_ren`=0, `out_valid`=0 and `count`=0. In the first post-reset cycle, `fifo_ren`=1.
- Stream 0x1,0x2,…,0x8 with `out_ready`=1 throughout: `out_data` carries 0x1..0x8 on 8 consecutive cycles starting one cycle after the first `fifo_ren`, with `count` stable at 1.
- Stream with `out_ready`=0 for 5 cycles: exactly 2 pops occur (0x1, 0x2), `count`=2 and `fifo_ren`=0. After release, 0x1 then 0x2 then 0x3 arrive on back-to-back cycles.
- Random `out_ready` (50%) over 200 items with a random `fifo_empty` pattern: the scoreboard shows in-order, lossless delivery and no `out_data` change while stalled.
- Flush (macro on) in FULL holding 0xA,0xB: next cycle `count`=0, `out_valid`=0, no pop in the flush cycle. The subsequent output is the FIFO's then-current head, never 0xA or 0xB.
- Same flush stimulus with the macro off: `flush` has no effect, and 0xA, 0xB are delivered normally.
